// File: rtl/av_stream_mac.sv
// Streaming attention A x V engine: V is loaded once, then each A row is multiplied
// against V across E signed MAC lanes and returned as a rounded, saturated Z row.
module av_stream_mac #(
  parameter int DATA_WIDTH = 16,
  parameter int L          = 8,
  parameter int E          = 8,
  parameter int FRAC_SHIFT = 15,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH + $clog2(L)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    v_load_valid,
  output logic                    v_load_ready,
  input  logic [DATA_WIDTH*E-1:0] v_load_data,
  input  logic                    v_reload,
  input  logic                    a_valid,
  output logic                    a_ready,
  input  logic [DATA_WIDTH*L-1:0] a_data,
  input  logic [2*L-1:0]          a_prec,
  output logic                    z_valid,
  input  logic                    z_ready,
  output logic [DATA_WIDTH*E-1:0] z_data,
  output logic                    row_sat
);

  localparam int KW = (L > 1) ? $clog2(L) : 1;
  localparam int PW = 2*DATA_WIDTH;
  localparam int RW = ACC_WIDTH + 1;
  localparam logic signed [RW-1:0] HALF = {{(RW-FRAC_SHIFT){1'b0}}, 1'b1, {(FRAC_SHIFT-1){1'b0}}};
  localparam logic signed [RW-1:0] ZMAX = {{(RW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [RW-1:0] ZMIN = {{(RW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {S_LOADV, S_IDLE, S_MAC, S_DRAIN, S_OUT} state_t;

  state_t                        state, state_nxt;
  logic [KW-1:0]                 v_cnt, k;
  logic [DATA_WIDTH*E-1:0]       v_mem [L];
  logic [DATA_WIDTH*L-1:0]       a_row;
  logic [2*L-1:0]                prec_row;
  logic signed [DATA_WIDTH-1:0]  a_k;
  logic [DATA_WIDTH*E-1:0]       v_k;
  logic signed [PW-1:0]          prod_p1 [E];
  logic signed [ACC_WIDTH-1:0]   acc_p2 [E];
  logic                          vld_p1, last_p1, done_p2;
  logic                          v_hs, a_hs;
  logic [DATA_WIDTH*E-1:0]       z_nxt;
  logic                          sat_nxt;
  logic [DATA_WIDTH:0]           rs;

  // Precision masking keeps only the top bits of the A operand.
  function automatic logic signed [DATA_WIDTH-1:0] mask_a(input logic [DATA_WIDTH-1:0] a,
                                                          input logic [1:0] code);
    logic [DATA_WIDTH-1:0] m;
    case (code)
      2'd0:    m = {{4{1'b1}}, {(DATA_WIDTH-4){1'b0}}};
      2'd1:    m = {{8{1'b1}}, {(DATA_WIDTH-8){1'b0}}};
      default: m = '1;
    endcase
    return $signed(a & m);
  endfunction

  // Returns {clamped, value}: round-half-up via arithmetic shift, then clamp.
  function automatic logic [DATA_WIDTH:0] round_sat(input logic signed [ACC_WIDTH-1:0] acc);
    logic signed [RW-1:0] r;
    r = (RW'(acc) + HALF) >>> FRAC_SHIFT;
    if (r > ZMAX)      return {1'b1, ZMAX[DATA_WIDTH-1:0]};
    else if (r < ZMIN) return {1'b1, ZMIN[DATA_WIDTH-1:0]};
    else               return {1'b0, r[DATA_WIDTH-1:0]};
  endfunction

  assign v_hs = v_load_valid && (state == S_LOADV);
  assign a_hs = a_valid && (state == S_IDLE) && !v_reload;
  assign a_k  = mask_a(a_row[k*DATA_WIDTH +: DATA_WIDTH], prec_row[2*k +: 2]);
  assign v_k  = v_mem[k];

  always_comb begin
    state_nxt    = state;
    v_load_ready = 1'b0;
    a_ready      = 1'b0;
    z_valid      = 1'b0;
    case (state)
      S_LOADV: begin
        v_load_ready = 1'b1;
        if (v_hs && v_cnt == KW'(L-1)) state_nxt = S_IDLE;
      end
      S_IDLE: begin
        a_ready = !v_reload;
        if (v_reload)     state_nxt = S_LOADV;
        else if (a_valid) state_nxt = S_MAC;
      end
      S_MAC:   if (k == KW'(L-1)) state_nxt = S_DRAIN;
      // Hold until the final product has been folded into the accumulators.
      S_DRAIN: if (done_p2) state_nxt = S_OUT;
      S_OUT: begin
        z_valid = 1'b1;
        if (z_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_LOADV;
    endcase
  end

  always_comb begin
    z_nxt   = '0;
    sat_nxt = 1'b0;
    rs      = '0;
    for (int e = 0; e < E; e++) begin
      rs = round_sat(acc_p2[e]);
      z_nxt[e*DATA_WIDTH +: DATA_WIDTH] = rs[DATA_WIDTH-1:0];
      sat_nxt = sat_nxt | rs[DATA_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_LOADV;
      v_cnt    <= '0;
      k        <= '0;
      a_row    <= '0;
      prec_row <= '0;
      z_data   <= '0;
      row_sat  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (v_hs) v_cnt <= (v_cnt == KW'(L-1)) ? '0 : v_cnt + 1'b1;
      if (a_hs) begin
        a_row    <= a_data;
        prec_row <= a_prec;
        k        <= '0;
      end else if (state == S_MAC) begin
        k <= k + 1'b1;
      end
      if (state == S_DRAIN && done_p2) begin
        z_data  <= z_nxt;
        row_sat <= sat_nxt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (v_hs) v_mem[v_cnt] <= v_load_data;
  end

  // p1: per-lane product register; p2: accumulator update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      done_p2 <= 1'b0;
      for (int e = 0; e < E; e++) begin
        prod_p1[e] <= '0;
        acc_p2[e]  <= '0;
      end
    end else begin
      vld_p1  <= (state == S_MAC);
      last_p1 <= (state == S_MAC) && (k == KW'(L-1));
      done_p2 <= vld_p1 && last_p1;
      for (int e = 0; e < E; e++) begin
        if (state == S_MAC)
          prod_p1[e] <= PW'(a_k) * PW'($signed(v_k[e*DATA_WIDTH +: DATA_WIDTH]));
        if (a_hs)        acc_p2[e] <= '0;
        else if (vld_p1) acc_p2[e] <= acc_p2[e] + ACC_WIDTH'(prod_p1[e]);
      end
    end
  end

endmodule

// File: tb/tb_av_stream_mac.sv
// Directed-vector bench for av_stream_mac at DW=16, L=4, E=2, FRAC_SHIFT=15.
module tb_av_stream_mac;
  localparam int DW = 16;
  localparam int L  = 4;
  localparam int E  = 2;
  localparam int FS = 15;
  localparam int NV = 9;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            v_load_valid = 1'b0;
  logic            v_load_ready;
  logic [DW*E-1:0] v_load_data = '0;
  logic            v_reload = 1'b0;
  logic            a_valid = 1'b0;
  logic            a_ready;
  logic [DW*L-1:0] a_data = '0;
  logic [2*L-1:0]  a_prec = '0;
  logic            z_valid;
  logic            z_ready = 1'b0;
  logic [DW*E-1:0] z_data;
  logic            row_sat;

  typedef struct {
    string                  name;
    logic [L-1:0][DW*E-1:0] v;
    logic [L-1:0][DW-1:0]   a;
    logic [2*L-1:0]         prec;
    logic [DW*E-1:0]        z;
    logic                   sat;
  } vec_t;

  vec_t vecs [NV];
  int   total = 0;
  int   bad   = 0;
  int   n;

  always #5 clk = ~clk;

  av_stream_mac #(.DATA_WIDTH(DW), .L(L), .E(E), .FRAC_SHIFT(FS)) dut (
    .clk(clk), .rst_n(rst_n),
    .v_load_valid(v_load_valid), .v_load_ready(v_load_ready), .v_load_data(v_load_data),
    .v_reload(v_reload),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data), .a_prec(a_prec),
    .z_valid(z_valid), .z_ready(z_ready), .z_data(z_data), .row_sat(row_sat)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic load_v(input logic [L-1:0][DW*E-1:0] v, input bit reload);
    if (reload) begin
      v_reload = 1'b1;
      @(negedge clk);
      v_reload = 1'b0;
    end
    chk("v_load_ready before load", {31'b0, v_load_ready}, 32'd1);
    for (int r = 0; r < L; r++) begin
      v_load_valid = 1'b1;
      v_load_data  = v[r];
      @(negedge clk);
    end
    v_load_valid = 1'b0;
  endtask

  task automatic start_row(input int i);
    a_data  = vecs[i].a;
    a_prec  = vecs[i].prec;
    a_valid = 1'b1;
    chk({vecs[i].name, " a_ready"}, {31'b0, a_ready}, 32'd1);
    @(negedge clk);
    a_valid = 1'b0;
  endtask

  task automatic wait_z(input int i);
    n = 0;
    while (!z_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({vecs[i].name, " latency"}, n, L + 2);
    chk({vecs[i].name, " z_data"}, z_data, vecs[i].z);
    chk({vecs[i].name, " row_sat"}, {31'b0, row_sat}, {31'b0, vecs[i].sat});
  endtask

  task automatic finish_row(input int i);
    @(negedge clk);
    chk({vecs[i].name, " z_valid after handshake"}, {31'b0, z_valid}, 32'd0);
    chk({vecs[i].name, " a_ready after handshake"}, {31'b0, a_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{"basic",   {4{32'h2000_2000}}, {4{16'h2000}}, 8'hAA, 32'h2000_2000, 1'b0};
    vecs[1] = '{"sat_pos", {4{32'h4000_4000}}, {4{16'h4000}}, 8'hAA, 32'h7FFF_7FFF, 1'b1};
    vecs[2] = '{"mask4",   {{3{32'h1234_1234}}, 32'h7FFF_7FFF}, {16'h0, 16'h0, 16'h0, 16'h1FFF},
                8'hA8, 32'h1000_1000, 1'b0};
    vecs[3] = '{"mask8",   {{3{32'h1234_1234}}, 32'h7FFF_7FFF}, {16'h0, 16'h0, 16'h0, 16'h1FFF},
                8'hA9, 32'h1F00_1F00, 1'b0};
    vecs[4] = '{"full",    {{3{32'h1234_1234}}, 32'h7FFF_7FFF}, {16'h0, 16'h0, 16'h0, 16'h1FFF},
                8'hAA, 32'h1FFF_1FFF, 1'b0};
    vecs[5] = '{"signed",  {{3{32'h1234_1234}}, 32'h0001_4000}, {16'h0, 16'h0, 16'h0, 16'h8000},
                8'hAA, 32'hFFFF_C000, 1'b0};
    vecs[6] = '{"zero_a",  {4{32'h7FFF_7FFF}}, {4{16'h0000}}, 8'h00, 32'h0000_0000, 1'b0};
    vecs[7] = '{"negneg",  {4{32'h8000_8000}}, {4{16'h8000}}, 8'hFF, 32'h7FFF_7FFF, 1'b1};
    vecs[8] = '{"sat_neg", {4{32'h7FFF_7FFF}}, {4{16'h8000}}, 8'hAA, 32'h8000_8000, 1'b1};

    repeat (2) @(negedge clk);
    chk("reset v_load_ready", {31'b0, v_load_ready}, 32'd1);
    chk("reset a_ready", {31'b0, a_ready}, 32'd0);
    chk("reset z_valid", {31'b0, z_valid}, 32'd0);
    chk("reset z_data", z_data, 32'd0);
    chk("reset row_sat", {31'b0, row_sat}, 32'd0);
    rst_n = 1'b1;

    z_ready = 1'b1;
    for (int i = 0; i < NV; i++) begin
      load_v(vecs[i].v, i > 0);
      start_row(i);
      wait_z(i);
      finish_row(i);
    end

    // Backpressure: output must hold while the consumer stalls.
    z_ready = 1'b0;
    load_v(vecs[5].v, 1'b1);
    start_row(5);
    wait_z(5);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("stall z_valid", {31'b0, z_valid}, 32'd1);
      chk("stall z_data", z_data, vecs[5].z);
      chk("stall a_ready", {31'b0, a_ready}, 32'd0);
    end
    z_ready = 1'b1;
    finish_row(5);

    // Reload request wins over a simultaneous A row.
    v_reload = 1'b1;
    a_valid  = 1'b1;
    a_data   = vecs[0].a;
    a_prec   = vecs[0].prec;
    #1;
    chk("reload a_ready", {31'b0, a_ready}, 32'd0);
    @(negedge clk);
    chk("reload v_load_ready", {31'b0, v_load_ready}, 32'd1);
    chk("reload no accept", {31'b0, a_ready}, 32'd0);
    v_reload = 1'b0;
    a_valid  = 1'b0;
    load_v(vecs[1].v, 1'b0);
    start_row(1);
    wait_z(1);
    finish_row(1);

    // Reset in the middle of MAC.
    load_v(vecs[0].v, 1'b1);
    start_row(0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst z_valid", {31'b0, z_valid}, 32'd0);
    chk("midrst z_data", z_data, 32'd0);
    chk("midrst row_sat", {31'b0, row_sat}, 32'd0);
    chk("midrst v_load_ready", {31'b0, v_load_ready}, 32'd1);
    chk("midrst a_ready", {31'b0, a_ready}, 32'd0);
    @(negedge clk);
    rst_n   = 1'b1;
    a_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("postrst a_ready", {31'b0, a_ready}, 32'd0);
      chk("postrst z_valid", {31'b0, z_valid}, 32'd0);
    end
    a_valid = 1'b0;
    load_v(vecs[0].v, 1'b0);
    start_row(0);
    wait_z(0);
    finish_row(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
